// File: rtl/ad_ip_jesd204_tpl_dac_ext_sync.sv
// JESD204 TPL DAC external sync: arm/trigger sequencer that holds
// the sample stream at zero until a synchronized release.
module ad_ip_jesd204_tpl_dac_ext_sync #(
  parameter int EXT_SYNC   = 0,
  parameter int SYNC_DELAY = 0,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  link_clk,
  input  logic                  link_rstn,
  input  logic                  dac_ext_sync_arm,
  input  logic                  dac_ext_sync_disarm,
  input  logic                  dac_ext_sync_manual_req,
  input  logic                  dac_sync,
  input  logic                  sync_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  dac_sync_in_status,
  output logic                  dac_sync_out
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2
  } state_t;

  localparam logic [7:0] DLY = 8'(SYNC_DELAY);

  state_t state;
  state_t state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic rel;
  logic rel_nxt;

  logic sync_m1;
  logic sync_m2;
  logic sync_d;
  logic [1:0] fill;
  logic trig_ext;

  logic [DATA_WIDTH-1:0] data_nxt;
  logic status_nxt;
  logic sync_out_nxt;

  // fill masks the edge detector until sync_d holds a real sample,
  // so a level already high at reset release is not seen as an edge
  always_ff @(posedge link_clk or negedge link_rstn) begin
    if (!link_rstn) begin
      sync_m1 <= 1'b0;
      sync_m2 <= 1'b0;
      sync_d  <= 1'b0;
      fill    <= 2'd0;
    end else begin
      sync_m1 <= sync_in;
      sync_m2 <= sync_m1;
      sync_d  <= sync_m2;
      if (fill != 2'd3) begin
        fill <= fill + 2'd1;
      end
    end
  end

  assign trig_ext = (fill == 2'd3) & sync_m2 & ~sync_d;

  always_ff @(posedge link_clk or negedge link_rstn) begin
    if (!link_rstn) begin
      state <= ST_RUN;
      cnt   <= 8'd0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rel   <= rel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rel_nxt   = 1'b0;
    if (EXT_SYNC == 0) begin
      state_nxt = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (dac_ext_sync_arm && !dac_ext_sync_disarm) begin
            state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (dac_ext_sync_disarm) begin
            state_nxt = ST_RUN;
          end else if (trig_ext || dac_ext_sync_manual_req) begin
            state_nxt = ST_DELAY;
            cnt_nxt   = DLY;
          end
        end
        ST_DELAY: begin
          if (dac_ext_sync_disarm) begin
            state_nxt = ST_RUN;
          end else if (cnt == 8'd0) begin
            state_nxt = ST_RUN;
            rel_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // rel delays the release pulse one cycle so it lines up with the
  // first sample passed in RUN
  always_comb begin
    data_nxt     = '0;
    status_nxt   = (state_nxt != ST_RUN);
    sync_out_nxt = 1'b0;
    if (state == ST_RUN) begin
      data_nxt     = data_in;
      sync_out_nxt = rel | dac_sync;
    end
  end

  always_ff @(posedge link_clk or negedge link_rstn) begin
    if (!link_rstn) begin
      data_out           <= '0;
      dac_sync_in_status <= 1'b0;
      dac_sync_out       <= 1'b0;
    end else begin
      data_out           <= data_nxt;
      dac_sync_in_status <= status_nxt;
      dac_sync_out       <= sync_out_nxt;
    end
  end

endmodule
